ifetch_ctrl: RTL and testbench

Instruction-fetch controller that sequences the instruction memory. It owns the program counter, issues word-indexed read addresses to the instruction memory, and captures each returned instruction with its PC into a small circular queue. Decode consumes entries through a valid/ready handshake. It sits between the instruction memory and the decode stage, and accepts branch and jump redirects from execute.

---
 rtl/ifetch_pkg.sv | 13 +
 rtl/ifetch_queue.sv | 59 +++++
 rtl/ifetch_ctrl.sv | 117 +++++++++++
 tb/tb_ifetch_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared types/constants for the instruction-fetch slice.
// State encodings, NOP word and PC step.
package ifetch_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam int          PC_INC = 4;

endpackage

// File: rtl/ifetch_queue.sv
// Circular FIFO of {pc, instr} fetch entries with flush.
// Ports: push/pop/flush, din/dout (2*WIDTH), count, full, empty.
module ifetch_queue #(
  parameter int WIDTH  = 32,
  parameter int QDEPTH = 2
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        flush,
  input  logic [2*WIDTH-1:0]          din,
  output logic [2*WIDTH-1:0]          dout,
  output logic [$clog2(QDEPTH+1)-1:0] count,
  output logic                        full,
  output logic                        empty
);

  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(QDEPTH - 1);

  logic [2*WIDTH-1:0] mem [QDEPTH];
  logic [PW-1:0]      wptr;
  logic [PW-1:0]      rptr;

  assign dout  = mem[rptr];
  assign full  = (count == CW'(QDEPTH));
  assign empty = (count == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < QDEPTH; i++) begin
        mem[i] <= '0;
      end
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
      end
      if (pop) begin
        rptr <= (rptr == LAST) ? '0 : rptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ifetch_ctrl.sv
// Fetch controller: PC, imem sequencing, queue to decode, redirects.
// Ports: clk, rst_n, imem_*, redirect_*, if_* handshake, fetch_fault.
// Bounds check / FAULT state enabled by macro IFETCH_BOUNDS_EN.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 1024,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               QDEPTH   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_addr,
  input  logic [WIDTH-1:0] imem_instr,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             if_valid,
  input  logic             if_ready,
  output logic [WIDTH-1:0] if_instr,
  output logic [WIDTH-1:0] if_pc,
  output logic             fetch_fault
);

  localparam int CW = $clog2(QDEPTH + 1);

  if (QDEPTH < 1 || DEPTH < 1) begin : g_bad_cfg
    $error("ifetch_ctrl: QDEPTH and DEPTH must be >= 1");
  end

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   pc_q, pc_d;
  logic               push;
  logic               pop;
  logic               can_push;
  logic [CW-1:0]      q_count;
  logic               q_full;
  logic               q_empty;
  logic [2*WIDTH-1:0] q_dout;

  assign pop      = if_ready && !q_empty;
  assign if_valid = (q_count != '0);
  // A full queue can still take an entry when the head leaves.
  assign can_push = !q_full || pop;

  assign imem_read = push;
  assign imem_addr = pc_q >> 2;
  assign if_pc     = q_dout[2*WIDTH-1:WIDTH];
  assign if_instr  = q_dout[WIDTH-1:0];

`ifdef IFETCH_BOUNDS_EN
  logic oob;
  assign oob         = (pc_q >> 2) >= WIDTH'(DEPTH);
  assign fetch_fault = (state_q == FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push    = 1'b0;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_pc & ~WIDTH'(3);
    end else begin
      unique case (state_q)
        RUN: begin
          if (can_push) begin
`ifdef IFETCH_BOUNDS_EN
            if (oob) begin
              state_d = FAULT;
            end else begin
              push = 1'b1;
              pc_d = pc_q + WIDTH'(PC_INC);
            end
`else
            push = 1'b1;
            pc_d = pc_q + WIDTH'(PC_INC);
`endif
          end
        end
        FAULT: begin
          state_d = FAULT;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  ifetch_queue #(
    .WIDTH  (WIDTH),
    .QDEPTH (QDEPTH)
  ) u_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .din   ({pc_q, imem_instr}),
    .dout  (q_dout),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed bench for ifetch_ctrl: stream, backpressure, redirect,
// PC wrap, async reset, and bounds fault when IFETCH_BOUNDS_EN is set.
module tb_ifetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_read;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  logic        w_read;
  logic [31:0] w_addr;
  logic [31:0] w_instr;
  logic        w_valid;
  logic [31:0] w_if_instr;
  logic [31:0] w_if_pc;
  logic        w_fault;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  // Memory model: mem[i] = i + 100
  assign imem_instr = imem_addr + 32'd100;
  assign w_instr    = w_addr + 32'd100;

  ifetch_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_read      (imem_read),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc),
    .fetch_fault    (fetch_fault)
  );

  ifetch_ctrl #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_wrap (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_read      (w_read),
    .imem_addr      (w_addr),
    .imem_instr     (w_instr),
    .redirect_valid (1'b0),
    .redirect_pc    (32'h0),
    .if_valid       (w_valid),
    .if_ready       (1'b1),
    .if_instr       (w_if_instr),
    .if_pc          (w_if_pc),
    .fetch_fault    (w_fault)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic head(input string tag,
                      input logic [31:0] pc,
                      input logic [31:0] ins);
    check({tag, "_valid"}, 32'(if_valid), 32'd1);
    check({tag, "_pc"}, if_pc, pc);
    check({tag, "_instr"}, if_instr, ins);
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", 32'(if_valid), 32'd0);
    check("rst_pc", if_pc, 32'd0);
    check("rst_instr", if_instr, 32'd0);
    check("rst_fault", 32'(fetch_fault), 32'd0);
    check("rst_addr", imem_addr, 32'd0);

    // Stream with if_ready=1
    rst_n    = 1'b1;
    if_ready = 1'b1;
    #1;
    check("rel_read", 32'(imem_read), 32'd1);
    check("rel_valid", 32'(if_valid), 32'd0);
    @(negedge clk);
    head("s0", 32'd0, 32'd100);
`ifndef IFETCH_BOUNDS_EN
    check("wrap0_pc", w_if_pc, 32'hFFFF_FFFC);
    check("wrap0_instr", w_if_instr, 32'h4000_0063);
`endif
    @(negedge clk);
    head("s1", 32'd4, 32'd101);
`ifndef IFETCH_BOUNDS_EN
    check("wrap1_pc", w_if_pc, 32'h0);
    check("wrap1_instr", w_if_instr, 32'd100);
`endif
    @(negedge clk);
    head("s2", 32'd8, 32'd102);
    @(negedge clk);
    head("s3", 32'd12, 32'd103);

    // Redirect to 0 with backpressure
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    #1;
    check("rd0_read", 32'(imem_read), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("bp_empty", 32'(if_valid), 32'd0);
    check("bp_read0", 32'(imem_read), 32'd1);
    check("bp_addr0", imem_addr, 32'd0);
    @(negedge clk);
    head("bp_h0", 32'd0, 32'd100);
    check("bp_read1", 32'(imem_read), 32'd1);
    check("bp_addr1", imem_addr, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_stall_read", 32'(imem_read), 32'd0);
      check("bp_stall_addr", imem_addr, 32'd2);
      check("bp_stall_pc", if_pc, 32'd0);
    end
    if_ready = 1'b1;
    #1;
    check("bp_rel_read", 32'(imem_read), 32'd1);
    @(negedge clk);
    head("bp_d1", 32'd4, 32'd101);
    @(negedge clk);
    head("bp_d2", 32'd8, 32'd102);

    // Redirect to 0x43 while holding two entries; head 8 transfers
    redirect_valid = 1'b1;
    redirect_pc    = 32'h43;
    #1;
    check("rdx_pop_valid", 32'(if_valid), 32'd1);
    check("rdx_read", 32'(imem_read), 32'd0);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("rdx_flushed", 32'(if_valid), 32'd0);
    check("rdx_addr", imem_addr, 32'd16);
    check("rdx_read1", 32'(imem_read), 32'd1);
    @(negedge clk);
    head("rdx_h", 32'h40, 32'd116);
    @(negedge clk);
    head("rdx_h1", 32'h44, 32'd117);

`ifdef IFETCH_BOUNDS_EN
    // Bounds fault at the last word
    redirect_valid = 1'b1;
    redirect_pc    = 32'd4092;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("bf_read", 32'(imem_read), 32'd1);
    check("bf_addr", imem_addr, 32'd1023);
    @(negedge clk);
    head("bf_h", 32'd4092, 32'd1123);
    check("bf_oob_read", 32'(imem_read), 32'd0);
    check("bf_fault0", 32'(fetch_fault), 32'd0);
    @(negedge clk);
    check("bf_fault1", 32'(fetch_fault), 32'd1);
    check("bf_drained", 32'(if_valid), 32'd0);
    check("bf_noread", 32'(imem_read), 32'd0);
    @(negedge clk);
    check("bf_sticky", 32'(fetch_fault), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0;
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("bf_clear", 32'(fetch_fault), 32'd0);
    check("bf_resume", 32'(imem_read), 32'd1);
    @(negedge clk);
    head("bf_r0", 32'd0, 32'd100);
`endif

    // Async reset between edges
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("ar_valid", 32'(if_valid), 32'd0);
    check("ar_fault", 32'(fetch_fault), 32'd0);
    check("ar_addr", imem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    head("ar_h0", 32'd0, 32'd100);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
